// File: rtl/vscale_imem_responder_pkg.sv
// Shared widths, state encodings and default instruction for the instruction-fetch responder.
package vscale_imem_responder_pkg;

    localparam int XPR_LEN          = 32;
    localparam int INST_WIDTH       = 32;
    localparam int TAG_WIDTH        = XPR_LEN - 2;
    localparam int IMEM_STATE_WIDTH = 2;

    localparam logic [INST_WIDTH-1:0] RV_NOP = 32'h00000013;

    typedef enum logic [IMEM_STATE_WIDTH-1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } imem_state_e;

    // Fetches are word granular, so the low two byte-address bits never take part.
    function automatic logic [TAG_WIDTH-1:0] word_tag(input logic [XPR_LEN-1:0] addr);
        return addr[XPR_LEN-1:2];
    endfunction

endpackage

// File: rtl/vscale_imem_responder_if.sv
// Core fetch port plus valid/ready backing-memory port; slave is the responder side.
interface vscale_imem_responder_if;
    import vscale_imem_responder_pkg::*;

    logic                  imem_req;
    logic [XPR_LEN-1:0]    imem_addr;
    logic                  imem_flush;
    logic                  imem_wait;
    logic [INST_WIDTH-1:0] imem_rdata;
    logic                  imem_badmem_e;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [XPR_LEN-1:0]    mem_req_addr;
    logic                  mem_resp_valid;
    logic [INST_WIDTH-1:0] mem_resp_data;
    logic                  mem_resp_err;

    modport slave (
        input  imem_req, imem_addr, imem_flush,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        output imem_wait, imem_rdata, imem_badmem_e,
        output mem_req_valid, mem_req_addr
    );

    modport master (
        output imem_req, imem_addr, imem_flush,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        input  imem_wait, imem_rdata, imem_badmem_e,
        input  mem_req_valid, mem_req_addr
    );

endinterface

// File: rtl/vscale_imem_replay_buf.sv
// One-entry tag/data/valid store for the last fetched word; lookup is combinational.
// Clear wins over a same-edge fill, so a flushed or faulted word never becomes valid.
module vscale_imem_replay_buf
    import vscale_imem_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  fill,
    input  logic [TAG_WIDTH-1:0]  fill_tag,
    input  logic [INST_WIDTH-1:0] fill_data,
    input  logic [TAG_WIDTH-1:0]  lookup_tag,
    output logic                  hit,
    output logic [INST_WIDTH-1:0] data
);

    logic                  buf_valid;
    logic [TAG_WIDTH-1:0]  buf_addr;
    logic [INST_WIDTH-1:0] buf_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else begin
            if (fill) begin
                buf_addr <= fill_tag;
                buf_data <= fill_data;
            end
            if (clear) begin
                buf_valid <= 1'b0;
            end else if (fill) begin
                buf_valid <= 1'b1;
            end
        end
    end

    assign hit  = buf_valid && (buf_addr == lookup_tag);
    assign data = buf_data;

endmodule

// File: rtl/vscale_imem_responder.sv
// Instruction-fetch responder: replay hit in 1 cycle, miss in >=3 via valid/ready memory.
// imem_wait stalls the core for any miss; mem_req_valid holds until mem_req_ready.
module vscale_imem_responder
    import vscale_imem_responder_pkg::*;
#(
    parameter bit                    BUF_EN   = 1'b1,
    parameter int                    TIMEOUT  = 255,
    parameter logic [INST_WIDTH-1:0] NOP_INST = RV_NOP
) (
    input  logic                     clk,
    input  logic                     reset,
    vscale_imem_responder_if.slave   bus
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    imem_state_e           state;
    logic [TAG_WIDTH-1:0]  addr_q;
    logic [CW-1:0]         cnt;
    logic                  drop_pending;
    logic                  wait_q;
    logic [INST_WIDTH-1:0] rdata_q;
    logic                  badmem_q;
    logic                  req_valid_q;

    logic                  accept;
    logic                  hit;
    logic                  to_fire;
    logic                  drop_next;
    logic                  buf_clear;
    logic                  buf_fill;
    logic                  buf_hit;
    logic [INST_WIDTH-1:0] buf_data;

    assign accept    = bus.imem_req && !wait_q;
    assign hit       = accept && buf_hit && !bus.imem_flush;
    assign to_fire   = (state == S_WAIT) && !bus.mem_resp_valid && (cnt == CNT_LAST);
    assign drop_next = drop_pending && !bus.mem_resp_valid;
    assign buf_fill  = (state == S_WAIT) && bus.mem_resp_valid && !bus.mem_resp_err;
    assign buf_clear = bus.imem_flush || to_fire ||
                       ((state == S_WAIT) && bus.mem_resp_valid && bus.mem_resp_err);

    generate
        if (BUF_EN) begin : g_buf
            vscale_imem_replay_buf u_buf (
                .clk        (clk),
                .reset      (reset),
                .clear      (buf_clear),
                .fill       (buf_fill),
                .fill_tag   (addr_q),
                .fill_data  (bus.mem_resp_data),
                .lookup_tag (word_tag(bus.imem_addr)),
                .hit        (buf_hit),
                .data       (buf_data)
            );
        end else begin : g_nobuf
            assign buf_hit  = 1'b0;
            assign buf_data = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            cnt          <= '0;
            drop_pending <= 1'b0;
            wait_q       <= 1'b0;
            rdata_q      <= NOP_INST;
            badmem_q     <= 1'b0;
            req_valid_q  <= 1'b0;
        end else begin
            // After a timeout exactly one late response is still owed; swallow it.
            if (to_fire) begin
                drop_pending <= 1'b1;
            end else if (drop_pending && bus.mem_resp_valid) begin
                drop_pending <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q   <= word_tag(bus.imem_addr);
                        badmem_q <= 1'b0;
                        if (hit) begin
                            rdata_q <= buf_data;
                        end else begin
                            state       <= S_ISSUE;
                            wait_q      <= 1'b1;
                            req_valid_q <= !drop_next;
                        end
                    end
                end
                S_ISSUE: begin
                    if (req_valid_q && bus.mem_req_ready) begin
                        state       <= S_WAIT;
                        req_valid_q <= 1'b0;
                        cnt         <= '0;
                    end else begin
                        req_valid_q <= !drop_next;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (bus.mem_resp_valid || to_fire) begin
                        state  <= S_IDLE;
                        wait_q <= 1'b0;
                        if (bus.mem_resp_valid && !bus.mem_resp_err) begin
                            rdata_q  <= bus.mem_resp_data;
                            badmem_q <= 1'b0;
                        end else begin
                            rdata_q  <= NOP_INST;
                            badmem_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    wait_q      <= 1'b0;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_wait     = wait_q;
    assign bus.imem_rdata    = rdata_q;
    assign bus.imem_badmem_e = badmem_q;
    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = {addr_q, 2'b00};

    a_resp_only_when_owed: assert property (@(posedge clk) disable iff (reset)
        bus.mem_resp_valid |-> ((state == S_WAIT) || drop_pending));

    a_addr_stable_in_wait: assert property (@(posedge clk) disable iff (reset)
        wait_q |-> $stable(bus.imem_addr));

endmodule

// File: tb/tb_vscale_imem_responder.sv
// Directed bench: expected fetch results are queued at accept and checked when imem_wait drops.
module tb_vscale_imem_responder;
    import vscale_imem_responder_pkg::*;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] D1  = 32'h00500093;
    localparam logic [31:0] D2  = 32'h00a00113;
    localparam logic [31:0] D3  = 32'h00300193;
    localparam logic [31:0] D4  = 32'h00400213;

    typedef struct {
        logic [31:0] rdata;
        logic        bad;
    } exp_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    exp_t sb_q[$];

    vscale_imem_responder_if bus ();

    vscale_imem_responder #(
        .BUF_EN   (1'b1),
        .TIMEOUT  (8),
        .NOP_INST (NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] d, input logic b);
        exp_t ex;
        ex.rdata = d;
        ex.bad   = b;
        sb_q.push_back(ex);
    endtask

    task automatic sb_check(input string tag);
        exp_t ex;
        chk({tag, "_wait"}, 32'(bus.imem_wait), 32'd0);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed empty queue expected entry", tag);
        end else begin
            ex = sb_q.pop_front();
            chk({tag, "_rdata"}, bus.imem_rdata, ex.rdata);
            chk({tag, "_bad"}, 32'(bus.imem_badmem_e), 32'(ex.bad));
        end
    endtask

    // Miss: accept, hold off ready rdy_dly cycles, respond rsp_dly cycles after the handshake.
    task automatic miss_txn(input string tag, input logic [31:0] a, input int rdy_dly,
                            input int rsp_dly, input logic [31:0] d, input logic e,
                            input logic fl_resp, input logic fl_acc);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        sb_push(e ? NOP : d, e);
        bus.imem_req   = 1'b1;
        bus.imem_addr  = a;
        bus.imem_flush = fl_acc;
        tick();
        bus.imem_req   = 1'b0;
        bus.imem_flush = 1'b0;
        for (int i = 0; i <= rdy_dly; i++) begin
            chk({tag, "_req_vld"}, 32'(bus.mem_req_valid), 32'd1);
            chk({tag, "_req_addr"}, bus.mem_req_addr, wa);
            chk({tag, "_issue_wait"}, 32'(bus.imem_wait), 32'd1);
            if (i == rdy_dly) bus.mem_req_ready = 1'b1;
            tick();
        end
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
            chk({tag, "_wait_vld"}, 32'(bus.mem_req_valid), 32'd0);
            chk({tag, "_wait_wait"}, 32'(bus.imem_wait), 32'd1);
            if (i == rsp_dly - 1) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = d;
                bus.mem_resp_err   = e;
                bus.imem_flush     = fl_resp;
            end
            tick();
        end
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_err   = 1'b0;
        bus.imem_flush     = 1'b0;
        sb_check(tag);
    endtask

    task automatic hit_txn(input string tag, input logic [31:0] a, input logic [31:0] d);
        sb_push(d, 1'b0);
        bus.imem_req  = 1'b1;
        bus.imem_addr = a;
        tick();
        bus.imem_req  = 1'b0;
        chk({tag, "_no_req"}, 32'(bus.mem_req_valid), 32'd0);
        sb_check(tag);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.imem_req       = 1'b0;
        bus.imem_addr      = '0;
        bus.imem_flush     = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.mem_resp_err   = 1'b0;
        repeat (2) tick();
        chk("rst_wait", 32'(bus.imem_wait), 32'd0);
        chk("rst_rdata", bus.imem_rdata, NOP);
        chk("rst_bad", 32'(bus.imem_badmem_e), 32'd0);
        chk("rst_req_vld", 32'(bus.mem_req_valid), 32'd0);
        reset = 1'b0;
        tick();

        miss_txn("miss200", 32'h200, 0, 1, D1, 1'b0, 1'b0, 1'b0);
        hit_txn("hit202", 32'h202, D1);
        miss_txn("bp240", 32'h240, 4, 2, D2, 1'b0, 1'b0, 1'b0);
        miss_txn("evict200", 32'h200, 0, 1, D1, 1'b0, 1'b0, 1'b0);
        miss_txn("err300", 32'h300, 0, 2, 32'hbadbad00, 1'b1, 1'b0, 1'b0);
        miss_txn("refetch300", 32'h300, 0, 1, D3, 1'b0, 1'b0, 1'b0);
        hit_txn("hit301", 32'h301, D3);
        miss_txn("flushacc300", 32'h300, 1, 1, D3, 1'b0, 1'b0, 1'b1);

        // Hung memory: fault after 8 cycles in S_WAIT, then one late response is dropped.
        sb_push(NOP, 1'b1);
        bus.imem_req  = 1'b1;
        bus.imem_addr = 32'h500;
        tick();
        bus.imem_req  = 1'b0;
        chk("to_req_vld", 32'(bus.mem_req_valid), 32'd1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("to_still_wait", 32'(bus.imem_wait), 32'd1);
            tick();
        end
        sb_check("timeout");

        sb_push(D4, 1'b0);
        bus.imem_req  = 1'b1;
        bus.imem_addr = 32'h400;
        tick();
        bus.imem_req  = 1'b0;
        chk("drop_stall_wait", 32'(bus.imem_wait), 32'd1);
        chk("drop_stall_vld0", 32'(bus.mem_req_valid), 32'd0);
        tick();
        chk("drop_stall_vld1", 32'(bus.mem_req_valid), 32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hdeadbeef;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("drop_req_vld", 32'(bus.mem_req_valid), 32'd1);
        chk("drop_req_addr", bus.mem_req_addr, 32'h400);
        chk("drop_wait", 32'(bus.imem_wait), 32'd1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = D4;
        tick();
        bus.mem_resp_valid = 1'b0;
        sb_check("after_drop400");

        miss_txn("flushwait200", 32'h200, 0, 1, D1, 1'b0, 1'b1, 1'b0);
        miss_txn("reflush200", 32'h200, 0, 2, D1, 1'b0, 1'b0, 1'b0);

        // Reset while a request is pending in S_ISSUE.
        bus.imem_req  = 1'b1;
        bus.imem_addr = 32'h600;
        tick();
        bus.imem_req  = 1'b0;
        chk("mid_issue_vld", 32'(bus.mem_req_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_wait", 32'(bus.imem_wait), 32'd0);
        chk("mid_rst_vld", 32'(bus.mem_req_valid), 32'd0);
        chk("mid_rst_rdata", bus.imem_rdata, NOP);
        chk("mid_rst_bad", 32'(bus.imem_badmem_e), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        miss_txn("post_rst200", 32'h200, 0, 1, D1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vscale_imem_responder.md
Name: vscale_imem_responder

Overview:
- Responder end of the core's instruction-fetch interface.
- Samples the fetch address the PC mux drives in the PIF stage and returns the instruction word in the IF stage.
- Raises imem_wait until the word is available; the core holds the address stable during wait.
- Bridges to a valid/ready backing memory with variable latency. A one-entry replay buffer serves repeated fetches of the same word, and a watchdog turns a hung memory into a fetch fault.

Parameters:
BUF_EN, 1, 1 enables the one-entry replay buffer; 0 makes every fetch a miss
TIMEOUT, 255, max cycles in S_WAIT before fault; counter width = clog2(TIMEOUT+1)
NOP_INST, 32'h00000013, value of imem_rdata after reset and on fault

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high
imem_req  in  1  fetch request valid (PIF)
imem_addr  in  XPR_LEN  fetch byte address (PC_PIF)
imem_flush  in  1  invalidate replay buffer (fence.i)
imem_wait  out  1  requested word not yet available
imem_rdata  out  INST_WIDTH  instruction word (IF)
imem_badmem_e  out  1  fetch fault, valid when imem_wait=0
mem_req_valid  out  1  backing-memory request valid
mem_req_ready  in  1  backing memory accepts request
mem_req_addr  out  XPR_LEN  word-aligned address {addr_q[XPR_LEN-1:2],2'b00}
mem_resp_valid  in  1  response valid
mem_resp_data  in  32  response word
mem_resp_err  in  1  response error

Behaviour:
- Reset values:
  - state S_IDLE; imem_wait 0; imem_rdata NOP_INST; imem_badmem_e 0.
  - mem_req_valid 0; buf_valid 0; timeout counter 0.
- Accept: at a clk edge with imem_req=1 and imem_wait=0, capture addr_q<=imem_addr. Low 2 address bits are ignored for lookup and request.
- Hit: BUF_EN=1, buf_valid=1 and imem_addr[XPR_LEN-1:2]==buf_addr.
  - State stays S_IDLE.
  - Next cycle: imem_wait=0, imem_rdata=buf_data, badmem=0.
  - Latency is 1 cycle.
- Miss: state->S_ISSUE. imem_wait=1 from the next cycle.
- S_ISSUE: mem_req_valid=1, mem_req_addr from addr_q. When mem_req_ready=1 at an edge, go to S_WAIT with counter<=0.
- S_WAIT:
  - mem_req_valid=0; counter increments each cycle.
  - mem_resp_valid is ignored in any state other than S_WAIT.
  - Any response arriving before this state is entered is a protocol violation (assertion).
- Response with mem_resp_valid=1 and err=0:
  - rdata<=data; buf_data<=data; buf_addr<=addr_q[XPR_LEN-1:2]; buf_valid<=BUF_EN.
  - state->S_IDLE, so imem_wait drops the next cycle.
  - Minimum miss latency is 3 cycles: accept -> issue -> wait -> present.
- Response with err=1:
  - rdata<=NOP_INST, badmem<=1, buf_valid<=0, state->S_IDLE.
- Timeout: counter reaches TIMEOUT in S_WAIT with no response.
  - Same as the error path.
  - The state machine then ignores exactly one late response. It tracks this with a drop_pending flag; a new miss stalls in S_ISSUE until the flag clears.
- imem_badmem_e is held until the next accept.
- imem_wait = (state!=S_IDLE) || drop-stall.
- imem_req=0 in S_IDLE: no capture; outputs hold their last values.
- imem_flush:
  - buf_valid<=0 at the edge.
  - If flush is asserted in S_WAIT (or in the cycle the response arrives), the response is still delivered to imem_rdata but is not marked valid in the buffer.
  - A flush coinciding with an accept forces that accept to be treated as a miss.
- imem_addr changing while imem_wait=1 is an interface violation (assertion); the captured addr_q governs.
- Asserting reset mid-transaction:
  - Returns to reset values immediately.
  - An outstanding backing-memory response after reset is ignored, since state is S_IDLE.
- Sole state machine states: S_IDLE, S_ISSUE, S_WAIT.

Decomposition:
- Add to vscale_ctrl_constants.vh: IMEM_STATE_WIDTH and the S_IDLE/S_ISSUE/S_WAIT encodings.
- Add to rv32_opcodes.vh: RV_NOP (32'h00000013) as the default source for NOP_INST.
- Sub-module vscale_imem_replay_buf holds the one-entry tag/data/valid store with its flush and fill ports, so it can be stubbed when BUF_EN=0.
- The watchdog counter stays inline.

Test Plan:
- Reset, then miss on 0x200: req 0x200, ready=1 immediately, resp 0x00500093 two cycles later -> mem_req_addr=0x200; imem_wait high 2 cycles; then rdata=0x00500093 with badmem=0.
- Replay hit: fetch 0x200, then re-present 0x202 -> no mem_req_valid; next cycle wait=0 and rdata=0x00500093.
- Backpressure: mem_req_ready low 4 cycles -> mem_req_valid and address held stable; imem_wait high for the whole stall; data returned correctly.
- Error response on 0x300 -> rdata=0x00000013, badmem=1; refetch of 0x300 is a miss (mem_req_valid reasserts).
- Timeout with TIMEOUT=8 and no response -> badmem after 8 cycles in S_WAIT. A late response (data 0xdeadbeef) is dropped, and the next fetch of 0x400 returns its own data, not 0xdeadbeef.
- Flush during S_WAIT for 0x200 -> data delivered; immediate refetch of 0x200 misses. Reset asserted in S_ISSUE -> wait=0 and mem_req_valid=0 in the same cycle.
